// File: rtl/switch_filter_pkg.sv
// Shared constants, phase encoding and counter-width helper for the switch debounce filter.
package switch_filter_pkg;

  localparam int SWITCH_FILTER_WIDTH        = 16;
  localparam int SWITCH_FILTER_STABLE_COUNT = 20;

  // Switch positions consumed by the top-level pin-routing multiplexers.
  localparam int SW_PS2_SEL      = 12;
  localparam int SW_VGA_SEL      = 13;
  localparam int SW_AUDIO_SEL    = 14;
  localparam int SW_PROPPLUG_SEL = 15;

  typedef enum logic {
    PH_SETTLE = 1'b0,
    PH_FILTER = 1'b1
  } phase_e;

  function automatic int cnt_w(input int stable_count);
    return (stable_count < 2) ? 1 : $clog2(stable_count);
  endfunction

endpackage

// File: rtl/switch_filter_bit.sv
// One switch bit: optional 2-flop synchronizer (SWITCH_FILTER_SYNC_EN), stability counter,
// debounced flop and one-cycle change strobe.
module switch_filter_bit
  import switch_filter_pkg::*;
#(
  parameter int STABLE_COUNT = SWITCH_FILTER_STABLE_COUNT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sample_en,
  input  logic i_settled,
  input  logic i_switch,
  output logic o_db,
  output logic o_changed,
  output logic o_changed_nxt
);

  localparam int             CW       = cnt_w(STABLE_COUNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_COUNT - 1);

  logic          w_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_db;
  logic          w_db_nxt;
  logic          r_changed;
  logic          w_changed_nxt;

`ifdef SWITCH_FILTER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_switch};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = i_switch;
`endif

  // Settle phase adopts the pad level directly; filter phase needs STABLE_COUNT disagreeing strobes.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_db_nxt      = r_db;
    w_changed_nxt = 1'b0;
    if (i_sample_en) begin
      if (!i_settled) begin
        w_db_nxt = w_s;
      end else if (w_s == r_db) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_db_nxt      = w_s;
        w_cnt_nxt     = '0;
        w_changed_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_db      <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_db      <= w_db_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  assign o_db          = r_db;
  assign o_changed     = r_changed;
  assign o_changed_nxt = w_changed_nxt;

endmodule

// File: rtl/switch_filter.sv
// Slide-switch synchronizer/debounce filter: WIDTH independent bit filters plus the shared
// power-up settle phase and any_change strobe. Optional synchronizer: SWITCH_FILTER_SYNC_EN.
module switch_filter
  import switch_filter_pkg::*;
#(
  parameter int WIDTH        = SWITCH_FILTER_WIDTH,
  parameter int STABLE_COUNT = SWITCH_FILTER_STABLE_COUNT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] switch_db,
  output logic [WIDTH-1:0] changed,
  output logic             any_change,
  output logic             settled
);

  localparam int             SW          = cnt_w(STABLE_COUNT);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(STABLE_COUNT - 1);

  phase_e           r_phase;
  phase_e           w_phase_nxt;
  logic [SW-1:0]    r_settle_cnt;
  logic [SW-1:0]    w_settle_cnt_nxt;
  logic             r_any_change;
  logic             w_settled;
  logic [WIDTH-1:0] w_changed_nxt;

  assign w_settled = (r_phase == PH_FILTER);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    switch_filter_bit #(
      .STABLE_COUNT (STABLE_COUNT)
    ) u_bit (
      .i_clk         (clock),
      .i_reset       (reset),
      .i_sample_en   (sample_en),
      .i_settled     (w_settled),
      .i_switch      (switch_in[gi]),
      .o_db          (switch_db[gi]),
      .o_changed     (changed[gi]),
      .o_changed_nxt (w_changed_nxt[gi])
    );
  end

  // Settle window: counts strobes after reset, then latches into the filter phase.
  always_comb begin
    w_phase_nxt      = r_phase;
    w_settle_cnt_nxt = r_settle_cnt;
    case (r_phase)
      PH_SETTLE: begin
        if (sample_en) begin
          if (r_settle_cnt == SETTLE_LAST) begin
            w_phase_nxt      = PH_FILTER;
            w_settle_cnt_nxt = '0;
          end else begin
            w_settle_cnt_nxt = r_settle_cnt + SW'(1);
          end
        end
      end
      PH_FILTER: begin
        w_phase_nxt = PH_FILTER;
      end
      default: begin
        w_phase_nxt      = PH_SETTLE;
        w_settle_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase      <= PH_SETTLE;
      r_settle_cnt <= '0;
      r_any_change <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_any_change <= |w_changed_nxt;
    end
  end

  assign any_change = r_any_change;
  assign settled    = w_settled;

endmodule

// File: tb/tb_switch_filter.sv
// Self-checking bench for switch_filter; expected output words are queued per clock
// and compared after each rising edge. Handles builds with or without SWITCH_FILTER_SYNC_EN.
module tb_switch_filter;
  import switch_filter_pkg::*;

  localparam int W = SWITCH_FILTER_WIDTH;
  localparam int S = SWITCH_FILTER_STABLE_COUNT;
`ifdef SWITCH_FILTER_SYNC_EN
  localparam int SYNC_DLY = 2;
`else
  localparam int SYNC_DLY = 0;
`endif
  localparam int LAT = S - 1 + SYNC_DLY;
  localparam int OW  = 2 * W + 2;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic         sample_en;
  logic [W-1:0] switch_in;
  logic [W-1:0] switch_db;
  logic [W-1:0] changed;
  logic         any_change;
  logic         settled;

  always #5 clock = ~clock;

  switch_filter #(
    .WIDTH        (W),
    .STABLE_COUNT (S)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sample_en  (sample_en),
    .switch_in  (switch_in),
    .switch_db  (switch_db),
    .changed    (changed),
    .any_change (any_change),
    .settled    (settled)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [W-1:0]  cur_db;

  function automatic logic [OW-1:0] pack(input logic st, input logic [W-1:0] chg,
                                         input logic [W-1:0] db);
    return {st, |chg, chg, db};
  endfunction

  // Queue the word expected after the coming edge, then advance to #1 past that edge.
  task automatic step_clock(input logic [OW-1:0] exp);
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset(input string name, input logic [W-1:0] v);
    logic [OW-1:0] got, want;
    logic [W-1:0]  db;
    reset     = 1'b1;
    sample_en = 1'b1;
    switch_in = v;
    step_clock(pack(1'b0, '0, '0));
    got  = {settled, any_change, changed, switch_db};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s in_reset: got %h expected %h", name, got, want);
    end
    reset = 1'b0;
    for (int e = 0; e < S + 3; e++) begin
      db = (e >= SYNC_DLY) ? v : '0;
      step_clock(pack(e >= S - 1, '0, db));
      got  = {settled, any_change, changed, switch_db};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s settle e=%0d: got %h expected %h", name, e, got, want);
      end
    end
    cur_db = v;
  endtask

  // Clean step with sample_en high; every differing bit flips exactly LAT edges later.
  task automatic run_step(input string name, input logic [W-1:0] new_in);
    logic [OW-1:0] got, want;
    logic [W-1:0]  diff;
    sample_en = 1'b1;
    switch_in = new_in;
    diff      = new_in ^ cur_db;
    for (int e = 0; e < LAT + 3; e++) begin
      if (e < LAT)       want = pack(1'b1, '0, cur_db);
      else if (e == LAT) want = pack(1'b1, diff, new_in);
      else               want = pack(1'b1, '0, new_in);
      step_clock(want);
      got  = {settled, any_change, changed, switch_db};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s e=%0d: got %h expected %h", name, e, got, want);
      end
    end
    cur_db = new_in;
  endtask

  task automatic test_clean_step();
    logic [W-1:0] m;
    m = '0;
    m[SW_VGA_SEL] = 1'b1;
    run_step("step_vga_down", cur_db & ~m);
    run_step("step_vga_up", cur_db | m);
  endtask

  task automatic test_bounce();
    logic [OW-1:0] got, want;
    logic [W-1:0]  m, base;
    m = '0;
    m[SW_PROPPLUG_SEL] = 1'b1;
    base = cur_db;
    sample_en = 1'b1;
    for (int c = 0; c < 208; c++) begin
      switch_in = (c < 200 && ((c / 5) % 2) == 1) ? (base ^ m) : base;
      step_clock(pack(1'b1, '0, cur_db));
      got  = {settled, any_change, changed, switch_db};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bounce c=%0d: got %h expected %h", c, got, want);
      end
    end
  endtask

  task automatic test_strobed();
    logic [OW-1:0] got, want;
    logic [W-1:0]  m, new_in, db;
    int            n;
    bit            flipped;
    m = '0;
    m[SW_PS2_SEL] = 1'b1;
    new_in  = cur_db ^ m;
    switch_in = new_in;
    n       = 0;
    flipped = 1'b0;
    db      = cur_db;
    for (int e = 0; e < 92; e++) begin
      sample_en = (e % 4 == 0);
      if (sample_en && e >= SYNC_DLY && !flipped) n++;
      if (!flipped && n == S) begin
        flipped = 1'b1;
        db      = new_in;
        want    = pack(1'b1, m, db);
      end else begin
        want = pack(1'b1, '0, db);
      end
      step_clock(want);
      got  = {settled, any_change, changed, switch_db};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL strobed e=%0d: got %h expected %h", e, got, want);
      end
    end
    sample_en = 1'b1;
    cur_db    = new_in;
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] m;
    m = '0;
    m[SW_PS2_SEL]   = 1'b1;
    m[SW_AUDIO_SEL] = 1'b1;
    run_step("simultaneous", cur_db ^ m);
  endtask

  // S-1 disagreeing samples must not flip; a following full step must take the full count.
  task automatic test_boundary();
    logic [OW-1:0] got, want;
    logic [W-1:0]  base;
    base = cur_db;
    sample_en = 1'b1;
    for (int c = 0; c < S - 1 + SYNC_DLY + 4; c++) begin
      switch_in = (c < S - 1) ? (base ^ W'(1)) : base;
      step_clock(pack(1'b1, '0, cur_db));
      got  = {settled, any_change, changed, switch_db};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL boundary c=%0d: got %h expected %h", c, got, want);
      end
    end
    run_step("boundary_full", base ^ W'(1));
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] got, want;
    logic [W-1:0]  m;
    m = '0;
    m[SW_AUDIO_SEL] = 1'b1;
    sample_en = 1'b1;
    switch_in = cur_db ^ m;
    for (int e = 0; e < LAT; e++) begin
      step_clock(pack(1'b1, '0, cur_db));
      got  = {settled, any_change, changed, switch_db};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pending e=%0d: got %h expected %h", e, got, want);
      end
    end
    test_reset("reset_mid", 16'hA005);
    run_step("after_reset_step", cur_db ^ m);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    switch_in = '0;
    cur_db    = '0;
    test_reset("reset", 16'hA005);
    test_clean_step();
    test_bounce();
    test_strobed();
    test_simultaneous();
    test_boundary();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
